seq_cont_checker: RTL

Clocked stimulus/checker stage wrapped around a continuous-assignment pair under test. Drives the shared source variable `drive_a`, then samples the net-driven copy and the variable-driven copy after a programmable settle window. Emits one comparison record per step over a valid/ready handshake and counts net/variable disagreements. It sits both upstream of the assignment pair, as its driver, and downstream of it, as the consumer of its two outputs.

---
 rtl/seq_cont_pkg.sv | 36 +++
 rtl/seq_cont_checker_settle_timer.sv | 26 ++
 rtl/seq_cont_checker.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_cont_pkg.sv
// Shared types and the stimulus pattern for seq_cont_checker.
// SEQ_CONT_XZ_EN selects the four-state 0,1,x,z pattern instead of 0,1.
package seq_cont_pkg;

  localparam int SEQ_CONT_STEP_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_EMIT,
    ST_DONE
  } seq_cont_state_e;

  typedef struct packed {
    logic [SEQ_CONT_STEP_W-1:0] step;
    logic                       a;
    logic                       net;
    logic                       var_cp;
    logic                       match;
  } seq_cont_rec_t;

  function automatic logic seq_cont_pattern(input int unsigned n);
`ifdef SEQ_CONT_XZ_EN
    case (n % 4)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'bx;
      default: return 1'bz;
    endcase
`else
    return (n % 2) == 1;
`endif
  endfunction

endpackage

// File: rtl/seq_cont_checker_settle_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module settle_timer #(
  parameter int TIMER_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/seq_cont_checker.sv
// Drives drive_a, waits a settle window, captures the net and variable copies
// and emits one comparison record per step. Build option: SEQ_CONT_XZ_EN.
module seq_cont_checker
  import seq_cont_pkg::*;
#(
  parameter int  NUM_STEPS     = 8,
  parameter int  SETTLE_CYCLES = 1,
  parameter int  CNT_W         = 8,
  localparam int STEP_W        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              drive_a,
  input  logic              obs_net,
  input  logic              obs_var,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [STEP_W-1:0] rec_step,
  output logic              rec_a,
  output logic              rec_net,
  output logic              rec_var,
  output logic              rec_match,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int TIMER_W = ($clog2(SETTLE_CYCLES + 1) > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  seq_cont_state_e state_q, state_d;
  logic [STEP_W-1:0] step_q;
  logic              drive_q;
  seq_cont_rec_t     rec_q, rec_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              settle_done;
  logic              launch, capture, advance, last_step;

  // The timer is loaded while in DRIVE so SETTLE lasts exactly SETTLE_CYCLES.
  generate
    if (SETTLE_CYCLES > 0) begin : g_timer
      settle_timer #(
        .TIMER_W (TIMER_W)
      ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_DRIVE),
        .load_val (TIMER_W'(SETTLE_CYCLES - 1)),
        .expired  (settle_done)
      );
    end else begin : g_no_timer
      assign settle_done = 1'b1;
    end
  endgenerate

  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));
  assign launch    = (state_q == ST_IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_EMIT;
          capture = 1'b1;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_done) begin
          state_d = ST_EMIT;
          capture = 1'b1;
        end
      end
      ST_EMIT: begin
        if (rec_ready) begin
          if (last_step) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            advance = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Four-state compare: x/z matches only an identical x/z on the other copy.
  always_comb begin
    rec_d        = '0;
    rec_d.step   = SEQ_CONT_STEP_W'(step_q);
    rec_d.a      = drive_q;
    rec_d.net    = obs_net;
    rec_d.var_cp = obs_var;
    rec_d.match  = (obs_net === obs_var);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q  <= '0;
      drive_q <= 1'b0;
      rec_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (launch) begin
        step_q  <= '0;
        cnt_q   <= '0;
        drive_q <= seq_cont_pattern(32'd0);
      end else if (advance) begin
        step_q  <= step_q + 1'b1;
        drive_q <= seq_cont_pattern(32'(step_q) + 32'd1);
      end
      if (capture) begin
        rec_q <= rec_d;
        if (!rec_d.match && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign busy         = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_EMIT);
  assign done         = (state_q == ST_DONE);
  assign rec_valid    = (state_q == ST_EMIT);
  assign drive_a      = drive_q;
  assign rec_step     = STEP_W'(rec_q.step);
  assign rec_a        = rec_q.a;
  assign rec_net      = rec_q.net;
  assign rec_var      = rec_q.var_cp;
  assign rec_match    = rec_q.match;
  assign mismatch_cnt = cnt_q;

endmodule
